dtw_band_buffer: RTL and testbench

Parametrised successor to the DTW band shift register. It holds the previous DTW cost row for a banded DTW engine.
- Band radius is runtime-configurable up to MAX_R.
- Each stage carries a valid flag, so downstream logic can tell real costs from the infinity fill.
- Includes a flush mode that drains the row at end of sequence, plus an in_valid/in_ready handshake.
- Sits between the DTW cell datapath (producer of new costs) and the min-of-three comparator (consumer of last/band/out taps).

---
 rtl/dtw_pkg.sv | 19 +
 rtl/dtw_band_stage.sv | 29 ++
 rtl/dtw_band_buffer.sv | 137 +++++++++++++
 tb/tb_dtw_band_buffer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// Shared types and helpers for the banded DTW cost-row buffer.
package dtw_pkg;

  localparam int COST_W = 32;

  typedef logic [COST_W-1:0] cost_t;

  localparam cost_t COST_INF = {4'h0, {(COST_W-4){1'b1}}};

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} band_state_e;

  // Band radius must keep both the band and out taps inside the physical chain.
  function automatic int unsigned clamp_radius(input int unsigned r, input int unsigned max_r);
    if (r < 2) return 2;
    if (r > max_r) return max_r;
    return r;
  endfunction

endpackage

// File: rtl/dtw_band_stage.sv
// One cost-row stage: a cost word plus its valid flag, with reinit and shift.
module dtw_band_stage #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] INF_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= INF_VAL;
      q_valid <= 1'b0;
    end else if (clear) begin
      q       <= INF_VAL;
      q_valid <= 1'b0;
    end else if (shift) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/dtw_band_buffer.sv
// Previous-row cost buffer for a banded DTW engine: runtime radius, valid tracking,
// push handshake and an end-of-sequence drain.
module dtw_band_buffer
  import dtw_pkg::*;
#(
  parameter int               WIDTH   = COST_W,
  parameter int               MAX_R   = 16,
  parameter logic [WIDTH-1:0] INF_VAL = {4'h0, {(WIDTH-4){1'b1}}},
  localparam int              RW      = $clog2(MAX_R+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             cfg_load,
  input  logic [RW-1:0]    r_cfg,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] band,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             primed,
  output logic [RW-1:0]    fill_cnt,
  output logic             busy
);

  band_state_e      state_reg, state_next;
  logic [RW-1:0]    r_eff_reg, r_eff_next;
  logic [RW-1:0]    fill_reg, fill_next;
  logic [WIDTH-1:0] stage_q [MAX_R];
  logic             stage_v [MAX_R];
  logic             push, drain, cfg_accept, stage_clear, stage_shift;
  logic [WIDTH-1:0] head_d;
  logic             head_v;
  logic [WIDTH-1:0] band_tap, out_tap;
  logic             out_v_tap;

  assign in_ready    = (state_reg != FLUSH);
  assign push        = in_valid && in_ready && !clear;
  assign drain       = (state_reg == FLUSH) && !clear;
  assign cfg_accept  = cfg_load && (state_reg == IDLE) && !clear && !push;
  // A radius change starts from an empty row so stale words beyond the old window never appear.
  assign stage_clear = clear || cfg_accept;
  assign stage_shift = push || drain;
  assign head_d      = drain ? INF_VAL : in_data;
  assign head_v      = !drain;

  generate
    for (genvar gi = 0; gi < MAX_R; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        dtw_band_stage #(.WIDTH(WIDTH), .INF_VAL(INF_VAL)) u_stage (
          .clk(clk), .rst(rst), .clear(stage_clear), .shift(stage_shift),
          .d(head_d), .d_valid(head_v), .q(stage_q[gi]), .q_valid(stage_v[gi])
        );
      end else begin : g_body
        dtw_band_stage #(.WIDTH(WIDTH), .INF_VAL(INF_VAL)) u_stage (
          .clk(clk), .rst(rst), .clear(stage_clear), .shift(stage_shift),
          .d(stage_q[gi-1]), .d_valid(stage_v[gi-1]), .q(stage_q[gi]), .q_valid(stage_v[gi])
        );
      end
    end
  endgenerate

  always_comb begin
    band_tap  = INF_VAL;
    out_tap   = INF_VAL;
    out_v_tap = 1'b0;
    for (int i = 0; i < MAX_R; i++) begin
      if (RW'(i) == r_eff_reg - RW'(2)) band_tap = stage_q[i];
      if (RW'(i) == r_eff_reg - RW'(1)) begin
        out_tap   = stage_q[i];
        out_v_tap = stage_v[i];
      end
    end
  end

  // fill_cnt tracks valid words inside the window exactly: during a drain it only
  // drops when a valid word leaves through the out tap.
  always_comb begin
    state_next = state_reg;
    fill_next  = fill_reg;
    r_eff_next = r_eff_reg;
    if (clear) begin
      state_next = IDLE;
      fill_next  = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (push) begin
            state_next = FILL;
            fill_next  = RW'(1);
          end else if (cfg_load) begin
            r_eff_next = RW'(clamp_radius(32'(r_cfg), MAX_R));
          end
        end
        FILL: begin
          if (push && fill_reg < r_eff_reg) begin
            fill_next = fill_reg + RW'(1);
            if (fill_reg + RW'(1) == r_eff_reg) state_next = RUN;
          end
          if (flush) state_next = FLUSH;
        end
        RUN: begin
          if (flush) state_next = FLUSH;
        end
        FLUSH: begin
          if (out_v_tap && fill_reg != '0) fill_next = fill_reg - RW'(1);
          if (fill_next == '0) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      r_eff_reg <= RW'(MAX_R);
      fill_reg  <= '0;
    end else begin
      state_reg <= state_next;
      r_eff_reg <= r_eff_next;
      fill_reg  <= fill_next;
    end
  end

  assign last      = stage_q[0];
  assign band      = band_tap;
  assign out       = out_tap;
  assign out_valid = out_v_tap;
  assign fill_cnt  = fill_reg;
  assign primed    = (fill_reg == r_eff_reg);
  assign busy      = (state_reg == FLUSH);

endmodule

// File: tb/tb_dtw_band_buffer.sv
// Directed bench for dtw_band_buffer: fill, radius clamp, drain, gaps, same-cycle cases, async reset.
module tb_dtw_band_buffer;
  import dtw_pkg::*;

  localparam int WIDTH = COST_W;
  localparam int MAX_R = 16;
  localparam int RW    = $clog2(MAX_R+1);
  localparam cost_t INF = COST_INF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          cfg_load = 1'b0;
  logic [RW-1:0] r_cfg = '0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  cost_t         in_data = '0;
  logic          in_ready;
  cost_t         last, band, out;
  logic          out_valid, primed, busy;
  logic [RW-1:0] fill_cnt;

  int total = 0;
  int bad   = 0;

  dtw_band_buffer #(.WIDTH(WIDTH), .MAX_R(MAX_R), .INF_VAL(INF)) dut (
    .clk(clk), .rst(rst), .clear(clear), .cfg_load(cfg_load), .r_cfg(r_cfg),
    .flush(flush), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .last(last), .band(band), .out(out), .out_valid(out_valid), .primed(primed),
    .fill_cnt(fill_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input cost_t d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    $display("push data=%0d last=%0d band=%0h out=%0h out_valid=%0b fill=%0d",
             d, last, band, out, out_valid, fill_cnt);
  endtask

  task automatic load_radius(input logic [RW-1:0] r);
    cfg_load = 1'b1;
    r_cfg    = r;
    tick();
    cfg_load = 1'b0;
    $display("cfg_load r_cfg=%0d", r);
  endtask

  task automatic start_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    $display("flush start busy=%0b in_ready=%0b", busy, in_ready);
  endtask

  task automatic drain_wait(output int n);
    n = 0;
    while (busy && n < 64) begin
      tick();
      n++;
    end
    $display("drain done after %0d cycles fill=%0d", n, fill_cnt);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (primed !== 1'b0) begin bad++; $display("FAIL reset_primed got=%0b exp=0", primed); end
    total++; if (fill_cnt !== RW'(0)) begin bad++; $display("FAIL reset_fill got=%0d exp=0", fill_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (last !== INF || band !== INF || out !== INF) begin
      bad++; $display("FAIL reset_taps got=%0h/%0h/%0h exp=%0h", last, band, out, INF);
    end
  endtask

  task automatic test_fill9();
    int n;
    load_radius(RW'(9));
    for (int k = 1; k <= 8; k++) push_word(cost_t'(k));
    total++; if (out_valid !== 1'b0 || primed !== 1'b0 || fill_cnt !== RW'(8)) begin
      bad++; $display("FAIL fill9_pre got=ov%0b pr%0b f%0d exp=ov0 pr0 f8", out_valid, primed, fill_cnt);
    end
    push_word(cost_t'(9));
    total++; if (out_valid !== 1'b1 || out !== cost_t'(1)) begin
      bad++; $display("FAIL fill9_out got=ov%0b out%0h exp=ov1 out1", out_valid, out);
    end
    total++; if (band !== cost_t'(2) || last !== cost_t'(9) || primed !== 1'b1) begin
      bad++; $display("FAIL fill9_taps got=band%0h last%0h pr%0b exp=band2 last9 pr1", band, last, primed);
    end
    start_flush();
    drain_wait(n);
    total++; if (n != 9 || fill_cnt !== RW'(0) || out !== INF) begin
      bad++; $display("FAIL fill9_drain got=n%0d f%0d out%0h exp=n9 f0 out%0h", n, fill_cnt, out, INF);
    end
  endtask

  task automatic test_cfg4_flush();
    cost_t exp_out [4] = '{cost_t'(30), cost_t'(40), cost_t'(50), INF};
    logic  exp_ov  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    load_radius(RW'(4));
    for (int k = 1; k <= 4; k++) push_word(cost_t'(10*k));
    total++; if (out !== cost_t'(10) || band !== cost_t'(20) || out_valid !== 1'b1) begin
      bad++; $display("FAIL cfg4_p4 got=out%0d band%0d ov%0b exp=out10 band20 ov1", out, band, out_valid);
    end
    push_word(cost_t'(50));
    total++; if (out !== cost_t'(20) || last !== cost_t'(50) || band !== cost_t'(30)) begin
      bad++; $display("FAIL cfg4_p5 got=out%0d last%0d band%0d exp=out20 last50 band30", out, last, band);
    end
    start_flush();
    total++; if (in_ready !== 1'b0 || busy !== 1'b1 || out !== cost_t'(20)) begin
      bad++; $display("FAIL flush_start got=rdy%0b busy%0b out%0d exp=rdy0 busy1 out20", in_ready, busy, out);
    end
    for (int s = 0; s < 4; s++) begin
      tick();
      $display("drain shift %0d out=%0h out_valid=%0b fill=%0d", s+1, out, out_valid, fill_cnt);
      total++; if (out !== exp_out[s] || out_valid !== exp_ov[s] || fill_cnt !== RW'(3-s)) begin
        bad++; $display("FAIL flush_shift%0d got=out%0h ov%0b f%0d exp=out%0h ov%0b f%0d",
                        s+1, out, out_valid, fill_cnt, exp_out[s], exp_ov[s], 3-s);
      end
    end
    total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_idle got=busy%0b rdy%0b exp=busy0 rdy1", busy, in_ready);
    end
  endtask

  task automatic test_clamp();
    int n;
    load_radius(RW'(1));
    push_word(cost_t'(100));
    total++; if (primed !== 1'b0 || fill_cnt !== RW'(1)) begin
      bad++; $display("FAIL clamp_lo_p1 got=pr%0b f%0d exp=pr0 f1", primed, fill_cnt);
    end
    push_word(cost_t'(101));
    total++; if (primed !== 1'b1 || out !== cost_t'(100) || band !== cost_t'(101)) begin
      bad++; $display("FAIL clamp_lo_p2 got=pr%0b out%0d band%0d exp=pr1 out100 band101", primed, out, band);
    end
    start_flush();
    drain_wait(n);
    total++; if (n != 2) begin bad++; $display("FAIL clamp_lo_drain got=%0d exp=2", n); end
    load_radius(RW'(31));
    for (int k = 1; k <= 15; k++) push_word(cost_t'(k));
    total++; if (primed !== 1'b0 || fill_cnt !== RW'(15)) begin
      bad++; $display("FAIL clamp_hi_p15 got=pr%0b f%0d exp=pr0 f15", primed, fill_cnt);
    end
    push_word(cost_t'(16));
    total++; if (primed !== 1'b1 || out !== cost_t'(1) || band !== cost_t'(2)) begin
      bad++; $display("FAIL clamp_hi_p16 got=pr%0b out%0d band%0d exp=pr1 out1 band2", primed, out, band);
    end
    start_flush();
    drain_wait(n);
    total++; if (n != 16 || fill_cnt !== RW'(0)) begin
      bad++; $display("FAIL clamp_hi_drain got=n%0d f%0d exp=n16 f0", n, fill_cnt);
    end
  endtask

  task automatic test_gaps();
    int n;
    cost_t exp_last, exp_out;
    logic  exp_ov;
    load_radius(RW'(4));
    for (int k = 0; k < 8; k++) begin
      push_word(cost_t'(5 + k));
      exp_last = cost_t'(5 + k);
      exp_ov   = (k >= 3);
      exp_out  = (k >= 3) ? cost_t'(2 + k) : INF;
      total++; if (last !== exp_last || out !== exp_out || out_valid !== exp_ov) begin
        bad++; $display("FAIL gap_push%0d got=last%0h out%0h ov%0b exp=last%0h out%0h ov%0b",
                        k, last, out, out_valid, exp_last, exp_out, exp_ov);
      end
      tick();
      $display("idle cycle last=%0h out=%0h", last, out);
      total++; if (last !== exp_last || out !== exp_out) begin
        bad++; $display("FAIL gap_hold%0d got=last%0h out%0h exp=last%0h out%0h", k, last, out, exp_last, exp_out);
      end
    end
    start_flush();
    drain_wait(n);
    total++; if (n != 4) begin bad++; $display("FAIL gap_drain got=%0d exp=4", n); end
  endtask

  task automatic test_flush_push();
    int n;
    for (int k = 1; k <= 3; k++) push_word(cost_t'(k));
    in_valid = 1'b1;
    in_data  = cost_t'(77);
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    $display("push+flush data=77 last=%0d out=%0d busy=%0b", last, out, busy);
    total++; if (last !== cost_t'(77) || out !== cost_t'(1) || fill_cnt !== RW'(4)) begin
      bad++; $display("FAIL fp_accept got=last%0d out%0d f%0d exp=last77 out1 f4", last, out, fill_cnt);
    end
    total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL fp_busy got=busy%0b rdy%0b exp=busy1 rdy0", busy, in_ready);
    end
    drain_wait(n);
    total++; if (n != 4 || out !== INF) begin
      bad++; $display("FAIL fp_drain got=n%0d out%0h exp=n4 out%0h", n, out, INF);
    end
  endtask

  task automatic test_clear_push();
    push_word(cost_t'(8));
    push_word(cost_t'(9));
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = cost_t'(55);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL cp_ready got=%0b exp=1", in_ready); end
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    $display("clear+push data=55 last=%0h out=%0h fill=%0d", last, out, fill_cnt);
    total++; if (last !== INF || band !== INF || out !== INF) begin
      bad++; $display("FAIL cp_taps got=%0h/%0h/%0h exp=%0h", last, band, out, INF);
    end
    total++; if (fill_cnt !== RW'(0) || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL cp_state got=f%0d ov%0b rdy%0b busy%0b exp=f0 ov0 rdy1 busy0",
                      fill_cnt, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_async_rst();
    for (int k = 1; k <= 4; k++) push_word(cost_t'(k));
    start_flush();
    tick();
    #3 rst = 1'b1;
    #1;
    $display("async rst busy=%0b out=%0h fill=%0d", busy, out, fill_cnt);
    total++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || primed !== 1'b0) begin
      bad++; $display("FAIL arst_ctrl got=busy%0b rdy%0b ov%0b pr%0b exp=busy0 rdy1 ov0 pr0",
                      busy, in_ready, out_valid, primed);
    end
    total++; if (fill_cnt !== RW'(0) || last !== INF || out !== INF) begin
      bad++; $display("FAIL arst_data got=f%0d last%0h out%0h exp=f0 taps%0h", fill_cnt, last, out, INF);
    end
    #1 rst = 1'b0;
    push_word(cost_t'(21));
    total++; if (last !== cost_t'(21) || fill_cnt !== RW'(1) || busy !== 1'b0) begin
      bad++; $display("FAIL arst_push got=last%0d f%0d busy%0b exp=last21 f1 busy0", last, fill_cnt, busy);
    end
    for (int k = 22; k <= 35; k++) push_word(cost_t'(k));
    total++; if (primed !== 1'b0) begin bad++; $display("FAIL arst_reff15 got=%0b exp=0", primed); end
    push_word(cost_t'(36));
    total++; if (primed !== 1'b1 || out !== cost_t'(21)) begin
      bad++; $display("FAIL arst_reff16 got=pr%0b out%0d exp=pr1 out21", primed, out);
    end
  endtask

  initial begin
    test_reset();
    test_fill9();
    test_cfg4_flush();
    test_clamp();
    test_gaps();
    test_flush_push();
    test_clear_push();
    test_async_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
